signed_bcd_conv_v: RTL and testbench



---
 rtl/calc_pkg.sv | 55 +++++
 rtl/bcd_add3_v.sv | 25 ++
 rtl/signed_bcd_conv_v.sv | 151 +++++++++++++++
 tb/tb_signed_bcd_conv_v.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the 7X-3Y+6Z calculator display path:
//               converter state encoding, BCD digit width, and active-low
//               7-segment (gfedcba) patterns with a digit decoder helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    // Converter state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of one packed BCD digit
    localparam int BCD_W = 4;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Map one BCD digit to its segment pattern; non-decimal codes blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3_v.sv
// ============================================================================
// Module      : bcd_add3_v
// Description : Double-dabble correction cell. Adds 3 to a BCD digit that is
//               5 or more so the following left shift carries correctly into
//               the next decimal digit.
// Ports       : i_digit [3:0] - scratch digit before correction
//               o_digit [3:0] - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_v
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    // Scratch digits never exceed 9 before correction, so the 4-bit sum
    // (at most 12) cannot overflow.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/signed_bcd_conv_v.sv
// ============================================================================
// Module      : signed_bcd_conv_v
// Description : Signed binary to sign + BCD magnitude converter using a
//               sequential shift-add-3 (double-dabble) engine, one iteration
//               per clock, with valid/ready handshakes on both sides. The
//               result is held until the downstream stage accepts it.
// Options     : BCD_CONV_SEG7_EN - adds registered active-low 7-segment
//               outputs (o_seg, o_seg_minus) with leading-zero blanking.
// Ports       : i_clk, i_rst          - clock (rising), async active-high reset
//               i_valid, i_fu, o_ready - operand handshake and signed operand
//               o_valid, i_ready       - result handshake
//               o_sign, o_bcd          - sign (1 = negative), BCD magnitude
//               o_seg, o_seg_minus     - segment drive (option only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_bcd_conv_v
    import calc_pkg::*;
#(
    parameter int DIN_W    = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic [DIN_W-1:0]          i_fu,
    output logic                      o_ready,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_sign,
    output logic [BCD_W*N_DIGITS-1:0] o_bcd
`ifdef BCD_CONV_SEG7_EN
    ,
    output logic [7*N_DIGITS-1:0]     o_seg,
    output logic                      o_seg_minus
`endif
);

    localparam int                C_CNT_W   = $clog2(DIN_W + 1);
    localparam int                C_BCD_TOT = BCD_W * N_DIGITS;
    localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(DIN_W - 1);

    logic [1:0]           r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [DIN_W-1:0]     r_mag;
    logic [C_BCD_TOT-1:0] r_scr;
    logic                 r_neg;

    logic [DIN_W-1:0]     w_abs;
    logic [C_BCD_TOT-1:0] w_adj;
    logic [C_BCD_TOT-1:0] w_scr_next;
    logic [DIN_W-1:0]     w_mag_next;

    // Two's-complement magnitude; the most negative value maps to
    // 2^(DIN_W-1), which still fits as an unsigned DIN_W-bit number.
    assign w_abs = i_fu[DIN_W-1] ? ((~i_fu) + DIN_W'(1)) : i_fu;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_add3
            bcd_add3_v u_add3 (
                .i_digit (r_scr[gi*BCD_W +: BCD_W]),
                .o_digit (w_adj[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // One iteration: correct every digit, then shift {scratch, mag} left.
    assign w_scr_next = {w_adj[C_BCD_TOT-2:0], r_mag[DIN_W-1]};
    assign w_mag_next = {r_mag[DIN_W-2:0], 1'b0};

    // Ready is masked by reset so no operand is taken while reset is held.
    assign o_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_valid = (r_state == ST_DONE);

`ifdef BCD_CONV_SEG7_EN
    logic [7*N_DIGITS-1:0] w_seg_next;

    // Digits above ones are blanked while they and every higher digit are 0.
    always_comb begin : p_seg
        logic       zero_run;
        logic [3:0] digit;
        w_seg_next = '1;
        zero_run   = 1'b1;
        digit      = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            digit    = w_scr_next[i*BCD_W +: BCD_W];
            zero_run = zero_run && (digit == 4'd0);
            if (zero_run && (i != 0)) begin
                w_seg_next[i*7 +: 7] = SEG_BLANK;
            end else begin
                w_seg_next[i*7 +: 7] = seg7_decode(digit);
            end
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mag       <= '0;
            r_scr       <= '0;
            r_neg       <= 1'b0;
            o_sign      <= 1'b0;
            o_bcd       <= '0;
`ifdef BCD_CONV_SEG7_EN
            o_seg       <= '1;
            o_seg_minus <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_neg   <= i_fu[DIN_W-1];
                        r_mag   <= w_abs;
                        r_scr   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_scr <= w_scr_next;
                    r_mag <= w_mag_next;
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    // Final iteration: publish the shifted scratch directly.
                    if (r_cnt == C_LAST) begin
                        o_sign      <= r_neg;
                        o_bcd       <= w_scr_next;
`ifdef BCD_CONV_SEG7_EN
                        o_seg       <= w_seg_next;
                        o_seg_minus <= !r_neg;
`endif
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_signed_bcd_conv_v.sv
// ============================================================================
// Module      : tb_signed_bcd_conv_v
// Description : Self-checking bench for signed_bcd_conv_v. Expected results
//               come from a decimal arithmetic model of sign and |value|.
//               Optional segment outputs checked when BCD_CONV_SEG7_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_bcd_conv_v;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_fu = 8'h00;
    logic        dn_ready = 1'b1;
    logic        dut_ready;
    logic        dut_valid;
    logic        dut_sign;
    logic [11:0] dut_bcd;
`ifdef BCD_CONV_SEG7_EN
    logic [20:0] dut_seg;
    logic        dut_minus;
`endif

    int n_vec = 0;
    int n_err = 0;

    signed_bcd_conv_v #(.DIN_W(8), .N_DIGITS(3)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .i_fu        (in_fu),
        .o_ready     (dut_ready),
        .o_valid     (dut_valid),
        .i_ready     (dn_ready),
        .o_sign      (dut_sign),
        .o_bcd       (dut_bcd)
`ifdef BCD_CONV_SEG7_EN
        ,
        .o_seg       (dut_seg),
        .o_seg_minus (dut_minus)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: decimal digits of |v| packed as hundreds/tens/ones.
    function automatic logic [11:0] model_bcd(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

`ifdef BCD_CONV_SEG7_EN
    function automatic logic [20:0] model_seg(input int v);
        logic [6:0] tab [10];
        int m, h, t, o;
        logic [6:0] sh, st;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        m  = (v < 0) ? -v : v;
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        sh = (h == 0) ? 7'h7F : tab[h];
        st = (h == 0 && t == 0) ? 7'h7F : tab[t];
        return {sh, st, tab[o]};
    endfunction
`endif

    // Called at a negedge with the DUT idle: offers one operand, then counts
    // cycles from the accept edge until o_valid is seen (bounded).
    task automatic do_conv(input logic [7:0] v, output int lat);
        in_fu    = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (dut_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (dut_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", dut_valid); end
        n_vec++; if (dut_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", dut_ready); end
        n_vec++; if (dut_sign !== 1'b0) begin n_err++; $display("FAIL reset_sign got=%b exp=0", dut_sign); end
        n_vec++; if (dut_bcd !== 12'h000) begin n_err++; $display("FAIL reset_bcd got=%h exp=000", dut_bcd); end
`ifdef BCD_CONV_SEG7_EN
        n_vec++; if (dut_seg !== {21{1'b1}}) begin n_err++; $display("FAIL reset_seg got=%h exp=1fffff", dut_seg); end
        n_vec++; if (dut_minus !== 1'b1) begin n_err++; $display("FAIL reset_minus got=%b exp=1", dut_minus); end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (dut_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", dut_ready); end
    endtask

    task automatic test_known();
        logic [7:0]  vals  [5];
        logic        signs [5];
        logic [11:0] bcds  [5];
        int lat;
        vals  = '{8'h7F, 8'h80, 8'hC3, 8'h00, 8'h05};
        signs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bcds  = '{12'h127, 12'h128, 12'h061, 12'h000, 12'h005};
        dn_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_conv(vals[k], lat);
            n_vec++; if (lat != 8) begin n_err++; $display("FAIL known_latency in=%h got=%0d exp=8", vals[k], lat); end
            n_vec++; if (dut_sign !== signs[k]) begin n_err++; $display("FAIL known_sign in=%h got=%b exp=%b", vals[k], dut_sign, signs[k]); end
            n_vec++; if (dut_bcd !== bcds[k]) begin n_err++; $display("FAIL known_bcd in=%h got=%h exp=%h", vals[k], dut_bcd, bcds[k]); end
            n_vec++; if (dut_ready !== 1'b0) begin n_err++; $display("FAIL known_ready_done in=%h got=%b exp=0", vals[k], dut_ready); end
`ifdef BCD_CONV_SEG7_EN
            n_vec++; if (dut_seg !== model_seg(int'($signed(vals[k])))) begin n_err++; $display("FAIL known_seg in=%h got=%h exp=%h", vals[k], dut_seg, model_seg(int'($signed(vals[k])))); end
            n_vec++; if (dut_minus !== ~signs[k]) begin n_err++; $display("FAIL known_minus in=%h got=%b exp=%b", vals[k], dut_minus, ~signs[k]); end
`endif
            @(negedge clk);
            n_vec++; if (dut_valid !== 1'b0) begin n_err++; $display("FAIL known_valid_pulse in=%h got=%b exp=0", vals[k], dut_valid); end
            n_vec++; if (dut_ready !== 1'b1) begin n_err++; $display("FAIL known_ready_idle in=%h got=%b exp=1", vals[k], dut_ready); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        dn_ready = 1'b0;
        do_conv(8'h2A, lat);
        n_vec++; if (lat != 8) begin n_err++; $display("FAIL bp_latency got=%0d exp=8", lat); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_fu    = 8'($urandom);
            @(negedge clk);
            if (dut_valid !== 1'b1 || dut_bcd !== 12'h042 || dut_sign !== 1'b0 || dut_ready !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold bad_cycles=%0d exp=0 last valid=%b bcd=%h ready=%b", bad, dut_valid, dut_bcd, dut_ready); end
        in_valid = 1'b0;
        dn_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (dut_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", dut_valid); end
        n_vec++; if (dut_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", dut_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        dn_ready = 1'b1;
        in_fu    = 8'h9C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (dut_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", dut_valid); end
        n_vec++; if (dut_bcd !== 12'h000) begin n_err++; $display("FAIL rstmid_bcd got=%h exp=000", dut_bcd); end
        n_vec++; if (dut_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got=%b exp=0", dut_ready); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dut_valid !== 1'b0 || dut_ready !== 1'b1) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rstmid_no_partial bad_cycles=%0d exp=0", seen); end
        do_conv(8'h05, lat);
        n_vec++; if (lat != 8) begin n_err++; $display("FAIL rstmid_next_latency got=%0d exp=8", lat); end
        n_vec++; if (dut_sign !== 1'b0 || dut_bcd !== 12'h005) begin n_err++; $display("FAIL rstmid_next_result got=%b/%h exp=0/005", dut_sign, dut_bcd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int  lat;
        time t_prev, t_now;
        dn_ready = 1'b1;
        t_prev   = 0;
        for (int v = -128; v <= 127; v++) begin
            do_conv(8'(v), lat);
            t_now = $time;
            n_vec++; if (lat != 8) begin n_err++; $display("FAIL sweep_latency in=%0d got=%0d exp=8", v, lat); end
            n_vec++; if (dut_sign !== (v < 0) || dut_bcd !== model_bcd(v)) begin
                n_err++; $display("FAIL sweep_result in=%0d got=%b/%h exp=%b/%h", v, dut_sign, dut_bcd, (v < 0), model_bcd(v));
            end
`ifdef BCD_CONV_SEG7_EN
            n_vec++; if (dut_seg !== model_seg(v) || dut_minus !== !(v < 0)) begin
                n_err++; $display("FAIL sweep_seg in=%0d got=%h/%b exp=%h/%b", v, dut_seg, dut_minus, model_seg(v), !(v < 0));
            end
`endif
            if (v > -128) begin
                n_vec++; if (t_now - t_prev != 100) begin n_err++; $display("FAIL sweep_interval in=%0d got=%0t exp=100", v, t_now - t_prev); end
            end
            t_prev = t_now;
            @(negedge clk);
            n_vec++; if (dut_valid !== 1'b0 || dut_ready !== 1'b1) begin
                n_err++; $display("FAIL sweep_handshake in=%0d got valid=%b ready=%b exp 0/1", v, dut_valid, dut_ready);
            end
        end
    endtask

    task automatic test_random();
        int lat, hold, v, bad;
        logic [7:0] raw;
        for (int k = 0; k < 24; k++) begin
            raw  = 8'($urandom);
            v    = int'($signed(raw));
            hold = $urandom_range(0, 4);
            dn_ready = 1'b0;
            do_conv(raw, lat);
            n_vec++; if (lat != 8 || dut_sign !== (v < 0) || dut_bcd !== model_bcd(v)) begin
                n_err++; $display("FAIL rand_result in=%0d lat=%0d got=%b/%h exp=8 %b/%h", v, lat, dut_sign, dut_bcd, (v < 0), model_bcd(v));
            end
            bad = 0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                if (dut_valid !== 1'b1 || dut_bcd !== model_bcd(v)) bad++;
            end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand_hold in=%0d bad_cycles=%0d exp=0", v, bad); end
            dn_ready = 1'b1;
            @(negedge clk);
            n_vec++; if (dut_valid !== 1'b0 || dut_ready !== 1'b1) begin
                n_err++; $display("FAIL rand_handshake in=%0d got valid=%b ready=%b exp 0/1", v, dut_valid, dut_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
